id_ex_stage: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32 core.
- Sits directly downstream of the ID-stage control decoder. Latches its ALUOp/ALUSrc/Mem/WB outputs together with operands, immediate, funct and register addresses, and presents them to EX.
- Detects a load in EX feeding the instruction in ID. On a hazard it stalls PC and IF/ID and inserts a bubble.
- Counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_stage_if.sv | 50 +++++
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID -> EX bus: decoded control, operands and register fields in, registered EX view out.
// The stall request back to IF/ID and the bubble counter also travel on this bus.
interface id_ex_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic [1:0]       ALUOp_i;
    logic             ALUSrc_i;
    logic [1:0]       Mem_i;
    logic             WB_i;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic [XLEN-1:0]  imm_i;
    logic [9:0]       funct_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [4:0]       rd_i;
    logic             flush_i;

    logic [1:0]       ALUOp_o;
    logic             ALUSrc_o;
    logic [1:0]       Mem_o;
    logic             WB_o;
    logic [XLEN-1:0]  rs1_data_o;
    logic [XLEN-1:0]  rs2_data_o;
    logic [XLEN-1:0]  imm_o;
    logic [9:0]       funct_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic [4:0]       rd_o;
    logic             valid_o;
    logic             stall_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    // ID-side driver
    modport master (
        output ALUOp_i, ALUSrc_i, Mem_i, WB_i, rs1_data_i, rs2_data_i, imm_i,
               funct_i, rs1_i, rs2_i, rd_i, flush_i,
        input  ALUOp_o, ALUSrc_o, Mem_o, WB_o, rs1_data_o, rs2_data_o, imm_o,
               funct_o, rs1_o, rs2_o, rd_o, valid_o, stall_o, bubble_cnt_o
    );

    // Pipeline register
    modport slave (
        input  ALUOp_i, ALUSrc_i, Mem_i, WB_i, rs1_data_i, rs2_data_i, imm_i,
               funct_i, rs1_i, rs2_i, rd_i, flush_i,
        output ALUOp_o, ALUSrc_o, Mem_o, WB_o, rs1_data_o, rs2_data_o, imm_o,
               funct_o, rs1_o, rs2_o, rd_o, valid_o, stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// A hazard or flush loads an all-zero bubble into EX; stall_o is the only combinational output.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    id_ex_stage_if.slave  bus
);
    localparam logic [1:0]       MEM_LOAD  = 2'b01;
    localparam logic [1:0]       MEM_STORE = 2'b10;
    localparam logic [1:0]       MEM_BAD   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       alu_op_q,   alu_op_d;
    logic             alu_src_q,  alu_src_d;
    logic [1:0]       mem_q,      mem_d;
    logic             wb_q,       wb_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]  imm_q,      imm_d;
    logic [9:0]       funct_q,    funct_d;
    logic [4:0]       rs1_q,      rs1_d;
    logic [4:0]       rs2_q,      rs2_d;
    logic [4:0]       rd_q,       rd_d;
    logic             valid_q,    valid_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic load_ex;
    logic use_rs2;
    logic hazard;
    logic bubble;

    // Hazard detection against the instruction currently held in EX
    always_comb begin
        load_ex = (mem_q == MEM_LOAD) && valid_q && (rd_q != 5'd0);
        use_rs2 = !bus.ALUSrc_i || (bus.Mem_i == MEM_STORE);
        hazard  = load_ex && ((bus.rs1_i == rd_q) || (use_rs2 && (bus.rs2_i == rd_q)));
        bubble  = bus.flush_i || hazard;
    end

    assign bus.stall_o = hazard && !bus.flush_i && !rst_i;

    // Next EX contents: zero bubble by default, otherwise the ID instruction
    always_comb begin
        alu_op_d     = '0;
        alu_src_d    = 1'b0;
        mem_d        = '0;
        wb_d         = 1'b0;
        rs1_data_d   = '0;
        rs2_data_d   = '0;
        imm_d        = '0;
        funct_d      = '0;
        rs1_d        = '0;
        rs2_d        = '0;
        rd_d         = '0;
        valid_d      = 1'b0;
        bubble_cnt_d = bubble_cnt_q;

        if (bubble) begin
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            alu_op_d   = bus.ALUOp_i;
            alu_src_d  = bus.ALUSrc_i;
            mem_d      = (bus.Mem_i == MEM_BAD) ? 2'b00 : bus.Mem_i;
            wb_d       = bus.WB_i;
            rs1_data_d = bus.rs1_data_i;
            rs2_data_d = bus.rs2_data_i;
            imm_d      = bus.imm_i;
            funct_d    = bus.funct_i;
            rs1_d      = bus.rs1_i;
            rs2_d      = bus.rs2_i;
            rd_d       = bus.rd_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            mem_q        <= '0;
            wb_q         <= 1'b0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            funct_q      <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            alu_op_q     <= alu_op_d;
            alu_src_q    <= alu_src_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            funct_q      <= funct_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ALUOp_o      = alu_op_q;
    assign bus.ALUSrc_o     = alu_src_q;
    assign bus.Mem_o        = mem_q;
    assign bus.WB_o         = wb_q;
    assign bus.rs1_data_o   = rs1_data_q;
    assign bus.rs2_data_o   = rs2_data_q;
    assign bus.imm_o        = imm_q;
    assign bus.funct_o      = funct_q;
    assign bus.rs1_o        = rs1_q;
    assign bus.rs2_o        = rs2_q;
    assign bus.rd_o         = rd_q;
    assign bus.valid_o      = valid_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use stalls, flush priority,
// counter saturation (CNT_W=4) and reset during a hazard.
module tb_id_ex_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Whole EX view packed for single comparisons
    logic [127:0] ex_all;
    assign ex_all = {bus.ALUOp_o, bus.ALUSrc_o, bus.Mem_o, bus.WB_o, bus.rs1_data_o,
                     bus.rs2_data_o, bus.imm_o, bus.funct_o, bus.rs1_o, bus.rs2_o,
                     bus.rd_o, bus.valid_o};

    function automatic logic [127:0] exp_ex(input logic [1:0] aluop, input logic alusrc,
                                            input logic [1:0] mem, input logic wb,
                                            input logic [31:0] d1, input logic [31:0] d2,
                                            input logic [31:0] imm, input logic [9:0] funct,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [4:0] rd, input logic valid);
        return {aluop, alusrc, mem, wb, d1, d2, imm, funct, rs1, rs2, rd, valid};
    endfunction

    task automatic drive(input logic [1:0] aluop, input logic alusrc, input logic [1:0] mem,
                         input logic wb, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [9:0] funct);
        bus.ALUOp_i    = aluop;
        bus.ALUSrc_i   = alusrc;
        bus.Mem_i      = mem;
        bus.WB_i       = wb;
        bus.rs1_i      = rs1;
        bus.rs2_i      = rs2;
        bus.rd_i       = rd;
        bus.rs1_data_i = d1;
        bus.rs2_data_i = d2;
        bus.imm_i      = imm;
        bus.funct_i    = funct;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus.flush_i = 1'b0;
        drive(2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 10'($urandom));
        tick();
        drive(2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 10'($urandom));
        tick();
        n_cmp++;
        if (ex_all !== 128'd0) begin
            n_err++; $display("FAIL reset_outputs got=%h want=0", ex_all);
        end
        n_cmp++;
        if (bus.bubble_cnt_o !== 4'd0) begin
            n_err++; $display("FAIL reset_cnt got=%0d want=0", bus.bubble_cnt_o);
        end
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL reset_stall got=%b want=0", bus.stall_o);
        end
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_pass_through();
        // add x3, x1, x2
        drive(2'b10, 1'b0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 10'h000);
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL pass_stall_pre got=%b want=0", bus.stall_o);
        end
        tick();
        n_cmp++;
        if (ex_all !== exp_ex(2'b10, 1'b0, 2'b00, 1'b1, 32'h5, 32'h7, 32'h0, 10'h000,
                              5'd1, 5'd2, 5'd3, 1'b1)) begin
            n_err++; $display("FAIL pass_add got=%h", ex_all);
        end
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL pass_stall_post got=%b want=0", bus.stall_o);
        end
        // Mem=11 must latch as none; sub funct and nonzero imm pass through
        drive(2'b01, 1'b1, 2'b11, 1'b0, 5'd9, 5'd10, 5'd11, 32'hDEADBEEF, 32'h12345678,
              32'hFFFFFFF0, 10'h100);
        tick();
        n_cmp++;
        if (ex_all !== exp_ex(2'b01, 1'b1, 2'b00, 1'b0, 32'hDEADBEEF, 32'h12345678,
                              32'hFFFFFFF0, 10'h100, 5'd9, 5'd10, 5'd11, 1'b1)) begin
            n_err++; $display("FAIL pass_mem11 got=%h", ex_all);
        end
    endtask

    task automatic test_load_use_rs2();
        // lw x5, 8(x2)
        drive(2'b00, 1'b1, 2'b01, 1'b1, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8, 10'h002);
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL lu_stall_c1 got=%b want=0", bus.stall_o);
        end
        tick();
        // add x7, x6, x5
        drive(2'b10, 1'b0, 2'b00, 1'b1, 5'd6, 5'd5, 5'd7, 32'h11, 32'h22, 32'h0, 10'h000);
        n_cmp++;
        if (bus.stall_o !== 1'b1) begin
            n_err++; $display("FAIL lu_stall_c2 got=%b want=1", bus.stall_o);
        end
        tick();
        n_cmp++;
        if (ex_all !== 128'd0) begin
            n_err++; $display("FAIL lu_bubble got=%h want=0", ex_all);
        end
        n_cmp++;
        if (bus.bubble_cnt_o !== 4'd1) begin
            n_err++; $display("FAIL lu_cnt got=%0d want=1", bus.bubble_cnt_o);
        end
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL lu_stall_c3 got=%b want=0", bus.stall_o);
        end
        tick();
        n_cmp++;
        if (ex_all !== exp_ex(2'b10, 1'b0, 2'b00, 1'b1, 32'h11, 32'h22, 32'h0, 10'h000,
                              5'd6, 5'd5, 5'd7, 1'b1)) begin
            n_err++; $display("FAIL lu_add_c4 got=%h", ex_all);
        end
    endtask

    task automatic test_no_false_hazard();
        // lw x0 then add reading x0
        drive(2'b00, 1'b1, 2'b01, 1'b1, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4, 10'h002);
        tick();
        drive(2'b10, 1'b0, 2'b00, 1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 10'h000);
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL nf_rd0 got=%b want=0", bus.stall_o);
        end
        tick();
        // lw x5 then addi x8, x6 with rs2 field = 5
        drive(2'b00, 1'b1, 2'b01, 1'b1, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, 10'h002);
        tick();
        drive(2'b10, 1'b1, 2'b00, 1'b1, 5'd6, 5'd5, 5'd8, 32'h3, 32'h0, 32'h1, 10'h000);
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL nf_addi got=%b want=0", bus.stall_o);
        end
        tick();
        n_cmp++;
        if (bus.valid_o !== 1'b1 || bus.bubble_cnt_o !== 4'd1) begin
            n_err++; $display("FAIL nf_addi_ex valid=%b cnt=%0d want 1/1", bus.valid_o,
                              bus.bubble_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        // lw x5 then lw x6, 0(x4): independent, no stall
        drive(2'b00, 1'b1, 2'b01, 1'b1, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 10'h002);
        tick();
        drive(2'b00, 1'b1, 2'b01, 1'b1, 5'd4, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, 10'h002);
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_indep got=%b want=0", bus.stall_o);
        end
        tick();
        // sw x6 -> 0(x9): store data on rs2 matches load rd
        drive(2'b00, 1'b1, 2'b10, 1'b0, 5'd9, 5'd6, 5'd0, 32'h0, 32'h0, 32'h0, 10'h002);
        n_cmp++;
        if (bus.stall_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_store got=%b want=1", bus.stall_o);
        end
        tick();
        tick();
        // lw x9 then addi using x9 on rs1
        drive(2'b00, 1'b1, 2'b01, 1'b1, 5'd2, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 10'h002);
        tick();
        drive(2'b10, 1'b1, 2'b00, 1'b1, 5'd9, 5'd1, 5'd10, 32'h0, 32'h0, 32'h1, 10'h000);
        n_cmp++;
        if (bus.stall_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_rs1 got=%b want=1", bus.stall_o);
        end
        tick();
        n_cmp++;
        if (bus.bubble_cnt_o !== 4'd3 || bus.valid_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_cnt cnt=%0d valid=%b want 3/0", bus.bubble_cnt_o,
                              bus.valid_o);
        end
        tick();
    endtask

    task automatic test_flush_vs_hazard();
        drive(2'b00, 1'b1, 2'b01, 1'b1, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 10'h002);
        tick();
        bus.flush_i = 1'b1;
        drive(2'b10, 1'b0, 2'b00, 1'b1, 5'd6, 5'd5, 5'd7, 32'h1, 32'h2, 32'h0, 10'h000);
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL fl_stall got=%b want=0", bus.stall_o);
        end
        tick();
        bus.flush_i = 1'b0;
        #1;
        n_cmp++;
        if (ex_all !== 128'd0 || bus.bubble_cnt_o !== 4'd4) begin
            n_err++; $display("FAIL fl_bubble ex=%h cnt=%0d want 0/4", ex_all,
                              bus.bubble_cnt_o);
        end
        tick();
        n_cmp++;
        if (bus.valid_o !== 1'b1 || bus.bubble_cnt_o !== 4'd4) begin
            n_err++; $display("FAIL fl_single valid=%b cnt=%0d want 1/4", bus.valid_o,
                              bus.bubble_cnt_o);
        end
    endtask

    task automatic test_saturation();
        bus.flush_i = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        bus.flush_i = 1'b0;
        #1;
        n_cmp++;
        if (bus.bubble_cnt_o !== 4'hF) begin
            n_err++; $display("FAIL sat_cnt got=%0d want=15", bus.bubble_cnt_o);
        end
        // lw x5 into EX, then reset while a dependent add sits in ID
        drive(2'b00, 1'b1, 2'b01, 1'b1, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 10'h002);
        tick();
        drive(2'b10, 1'b0, 2'b00, 1'b1, 5'd5, 5'd1, 5'd7, 32'h9, 32'h4, 32'h0, 10'h000);
        n_cmp++;
        if (bus.stall_o !== 1'b1) begin
            n_err++; $display("FAIL rsth_pre got=%b want=1", bus.stall_o);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL rsth_stall got=%b want=0", bus.stall_o);
        end
        tick();
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (ex_all !== 128'd0 || bus.bubble_cnt_o !== 4'd0) begin
            n_err++; $display("FAIL rsth_clear ex=%h cnt=%0d want 0/0", ex_all,
                              bus.bubble_cnt_o);
        end
        n_cmp++;
        if (bus.stall_o !== 1'b0) begin
            n_err++; $display("FAIL rsth_after got=%b want=0", bus.stall_o);
        end
        tick();
        n_cmp++;
        if (ex_all !== exp_ex(2'b10, 1'b0, 2'b00, 1'b1, 32'h9, 32'h4, 32'h0, 10'h000,
                              5'd5, 5'd1, 5'd7, 1'b1)) begin
            n_err++; $display("FAIL rsth_add got=%h", ex_all);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use_rs2();
        test_no_false_hazard();
        test_back_to_back();
        test_flush_vs_hazard();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
